// File: rtl/test_status_monitor.sv
// Run monitor: emulates the power-on reset pulse into the SoC, then watches per-hart commits for pass/stall/timeout.
// Every output is registered (one cycle after the inputs); there is no backpressure and commits are sampled every cycle.
module test_status_monitor #(
  parameter int NUM_HARTS        = 1,
  parameter int PC_WIDTH         = 32,
  parameter int RST_DELAY        = 6000,
  parameter int RST_PULSE        = 500,
  parameter int HEARTBEAT_CYCLES = 10000,
  parameter int STALL_CYCLES     = 1000000,
  parameter int TIMEOUT_CYCLES   = 60000000,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_HARTS-1:0]          wb_valid,
  input  logic [NUM_HARTS*PC_WIDTH-1:0] wb_pc,
  input  logic [NUM_HARTS-1:0]          wb_excp,
  input  logic [NUM_HARTS*6-1:0]        wb_excp_num,
  output logic                          core_reset_req,
  output logic                          heartbeat,
  output logic [2:0]                    heartbeat_hart,
  output logic [PC_WIDTH-1:0]           heartbeat_pc,
  output logic [NUM_HARTS-1:0]          hart_done,
  output logic [NUM_HARTS-1:0]          hart_stall,
  output logic [1:0]                    status,
  output logic                          fail_cause,
  output logic [5:0]                    leds
);

  typedef enum logic [2:0] {S_WAIT, S_PULSE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(RST_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(RST_PULSE - 1);
  localparam logic [CNT_WIDTH-1:0] HB_LAST    = CNT_WIDTH'(HEARTBEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STALL_LAST = CNT_WIDTH'(STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]           RR_LAST    = 3'(NUM_HARTS - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] seq_cnt;
  logic [CNT_WIDTH-1:0] tmo_cnt;
  logic [CNT_WIDTH-1:0] hb_cnt;
  logic [CNT_WIDTH-1:0] idle_cnt [NUM_HARTS];
  logic [PC_WIDTH-1:0]  lastpc   [NUM_HARTS];
  logic [2:0]           rr;
  logic                 hb_toggle;
  logic                 tmo_flag;
  logic [PC_WIDTH-1:0]  rr_pc;
  logic                 unused_excp_bits;

  // Only bit 5 of each exception code carries meaning here.
  assign unused_excp_bits = ^wb_excp_num;

  always_comb begin
    rr_pc = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (rr == 3'(h)) rr_pc = lastpc[h];
    end
  end

  assign leds = {status, fail_cause, hb_toggle, |hart_done, |hart_stall};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_WAIT;
      seq_cnt        <= '0;
      tmo_cnt        <= '0;
      hb_cnt         <= '0;
      rr             <= '0;
      hb_toggle      <= 1'b0;
      tmo_flag       <= 1'b0;
      core_reset_req <= 1'b0;
      heartbeat      <= 1'b0;
      heartbeat_hart <= '0;
      heartbeat_pc   <= '0;
      hart_done      <= '0;
      hart_stall     <= '0;
      status         <= 2'b00;
      fail_cause     <= 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        idle_cnt[h] <= '0;
        lastpc[h]   <= '0;
      end
    end else begin
      heartbeat <= 1'b0;
      case (state)
        S_WAIT: begin
          if (seq_cnt == DELAY_LAST) begin
            state          <= S_PULSE;
            seq_cnt        <= '0;
            core_reset_req <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + ONE;
          end
        end
        S_PULSE: begin
          if (seq_cnt == PULSE_LAST) begin
            state          <= S_RUN;
            seq_cnt        <= '0;
            core_reset_req <= 1'b0;
            status         <= 2'b01;
          end else begin
            seq_cnt <= seq_cnt + ONE;
          end
        end
        S_RUN: begin
          // Decisions look at flags registered on an earlier cycle, so a
          // success and a timeout landing together resolve in favour of PASS.
          if (&hart_done) begin
            state  <= S_PASS;
            status <= 2'b10;
          end else if (|hart_stall) begin
            state      <= S_FAIL;
            status     <= 2'b11;
            fail_cause <= 1'b0;
          end else if (tmo_flag) begin
            state      <= S_FAIL;
            status     <= 2'b11;
            fail_cause <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + ONE;
            if (tmo_cnt == TMO_LAST) tmo_flag <= 1'b1;
            if (hb_cnt == HB_LAST) begin
              hb_cnt         <= '0;
              heartbeat      <= 1'b1;
              heartbeat_hart <= rr;
              heartbeat_pc   <= rr_pc;
              hb_toggle      <= ~hb_toggle;
              rr             <= (rr == RR_LAST) ? 3'd0 : rr + 3'd1;
            end else begin
              hb_cnt <= hb_cnt + ONE;
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
              if (wb_valid[h]) begin
                lastpc[h]   <= wb_pc[h*PC_WIDTH +: PC_WIDTH];
                idle_cnt[h] <= '0;
                if (wb_excp[h] && wb_excp_num[h*6+5]) hart_done[h] <= 1'b1;
              end else if (!hart_done[h]) begin
                idle_cnt[h] <= idle_cnt[h] + ONE;
                if (idle_cnt[h] == STALL_LAST) hart_stall[h] <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Scoreboard bench for test_status_monitor: stimulus queues expected output events with cycle stamps,
// a monitor pops one per observed output event (change, heartbeat pulse or probe).
module tb_test_status_monitor;

  localparam int NH = 2;
  localparam int PW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NH-1:0]   wb_valid;
  logic [NH*PW-1:0] wb_pc;
  logic [NH-1:0]   wb_excp;
  logic [NH*6-1:0] wb_excp_num;
  logic            core_reset_req;
  logic            heartbeat;
  logic [2:0]      heartbeat_hart;
  logic [PW-1:0]   heartbeat_pc;
  logic [NH-1:0]   hart_done;
  logic [NH-1:0]   hart_stall;
  logic [1:0]      status;
  logic            fail_cause;
  logic [5:0]      leds;

  always #5 clock = ~clock;

  test_status_monitor #(
    .NUM_HARTS(NH), .PC_WIDTH(PW), .RST_DELAY(4), .RST_PULSE(3),
    .HEARTBEAT_CYCLES(8), .STALL_CYCLES(16), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_excp(wb_excp), .wb_excp_num(wb_excp_num), .core_reset_req(core_reset_req),
    .heartbeat(heartbeat), .heartbeat_hart(heartbeat_hart), .heartbeat_pc(heartbeat_pc),
    .hart_done(hart_done), .hart_stall(hart_stall), .status(status),
    .fail_cause(fail_cause), .leds(leds)
  );

  typedef struct {
    int         cyc;
    logic       req;
    logic       hb;
    logic [2:0] hh;
    logic [31:0] hpc;
    logic [1:0] done;
    logic [1:0] stall;
    logic [1:0] st;
    logic       fc;
    logic [5:0] leds;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  probe_req = 0;
  bit  finish_req = 1'b0;

  // Expected output state, updated by hand alongside each queued event.
  logic        m_req, m_fc, m_tog;
  logic [2:0]  m_hh;
  logic [31:0] m_hpc;
  logic [1:0]  m_done, m_stall, m_st;

  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  task automatic push_ev(input int c, input logic hb);
    ev_t e;
    e.cyc = c; e.req = m_req; e.hb = hb; e.hh = m_hh; e.hpc = m_hpc;
    e.done = m_done; e.stall = m_stall; e.st = m_st; e.fc = m_fc;
    e.leds = {m_st, m_fc, m_tog, |m_done, |m_stall};
    exp_q.push_back(e);
  endtask

  task automatic hb_ev(input int c, input logic [2:0] h, input logic [31:0] pc);
    m_hh = h; m_hpc = pc; m_tog = ~m_tog;
    push_ev(c, 1'b1);
  endtask

  task automatic model_zero();
    m_req = 0; m_fc = 0; m_tog = 0; m_hh = '0; m_hpc = '0;
    m_done = '0; m_stall = '0; m_st = '0;
  endtask

  task automatic clear_in();
    wb_valid = '0; wb_pc = '0; wb_excp = '0; wb_excp_num = '0;
  endtask

  task automatic commit(input int h, input logic [31:0] pc, input logic ex, input logic [5:0] num);
    wb_valid[h] = 1'b1;
    wb_pc[h*PW +: PW] = pc;
    wb_excp[h] = ex;
    wb_excp_num[h*6 +: 6] = num;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // Called on a falling edge; afterwards the DUT sits in WAIT cycle 0.
  task automatic rst();
    bit nz;
    nz = m_req || m_fc || m_tog || (m_hh != 0) || (m_hpc != 0) ||
         (m_done != 0) || (m_stall != 0) || (m_st != 0);
    model_zero();
    if (nz) push_ev(0, 1'b0);
    reset = 1'b1;
    clear_in();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic boot();
    m_req = 1; push_ev(4, 1'b0);
    m_req = 0; m_st = 2'b01; push_ev(7, 1'b0);
  endtask

  task automatic probe();
    @(posedge clock);
    #1;
    push_ev(cyc, 1'b0);
    probe_req++;
  endtask

  initial begin : monitor
    ev_t         e;
    logic [48:0] snap;
    logic [48:0] prev;
    int          probe_seen;
    prev = '0;
    probe_seen = 0;
    forever begin
      @(negedge clock);
      snap = {core_reset_req, heartbeat_hart, heartbeat_pc, hart_done, hart_stall, status, fail_cause, leds};
      if (heartbeat === 1'b1 || snap !== prev || probe_req != probe_seen) begin
        probe_seen = probe_req;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d req=%b hb=%b hh=%0d pc=%h done=%b stall=%b st=%b fc=%b leds=%b",
                   cyc, core_reset_req, heartbeat, heartbeat_hart, heartbeat_pc, hart_done, hart_stall, status, fail_cause, leds);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || core_reset_req !== e.req || heartbeat !== e.hb || heartbeat_hart !== e.hh ||
              heartbeat_pc !== e.hpc || hart_done !== e.done || hart_stall !== e.stall ||
              status !== e.st || fail_cause !== e.fc || leds !== e.leds)
            begin
              errors++;
              $display("FAIL event got/exp cyc=%0d/%0d req=%b/%b hb=%b/%b hh=%0d/%0d pc=%h/%h done=%b/%b stall=%b/%b st=%b/%b fc=%b/%b leds=%b/%b",
                       cyc, e.cyc, core_reset_req, e.req, heartbeat, e.hb, heartbeat_hart, e.hh, heartbeat_pc, e.hpc,
                       hart_done, e.done, hart_stall, e.stall, status, e.st, fail_cause, e.fc, leds, e.leds);
            end
        end
      end
      prev = snap;
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_events got=0 exp=%0d first_cyc=%0d", exp_q.size(), exp_q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog run_not_finished checks=%0d exp=finish", checks);
    $fatal(1);
  end

  initial begin : stimulus
    model_zero();
    clear_in();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Boot sequence and reset state.
    probe();
    boot();
    wait_until(10);

    // Heartbeat round-robin; a success commit during PULSE must be ignored.
    rst();
    boot();
    hb_ev(15, 3'd0, 32'h1c000100);
    hb_ev(23, 3'd1, 32'h1c000200);
    for (int c = 0; c <= 24; c++) begin
      wait_until(c);
      clear_in();
      if (c == 5)  commit(0, 32'hdead0000, 1'b1, 6'h20);
      if (c == 9)  commit(0, 32'h1c000100, 1'b0, 6'h00);
      if (c == 10) commit(1, 32'h1c000200, 1'b0, 6'h00);
    end

    // Pass: the heartbeat due on cycle 15 is suppressed.
    rst();
    boot();
    m_done = 2'b01; push_ev(11, 1'b0);
    m_done = 2'b11; push_ev(14, 1'b0);
    m_st = 2'b10;   push_ev(15, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      wait_until(c);
      clear_in();
      if (c == 10) commit(0, 32'h1c000300, 1'b1, 6'h20);
      if (c == 13) commit(1, 32'h1c000304, 1'b1, 6'h3f);
    end

    // Stall on hart1; hart0 exceptions lack bit 5 so never count as success.
    rst();
    boot();
    hb_ev(15, 3'd0, 32'h1c001034);
    hb_ev(23, 3'd1, 32'h1c002030);
    m_stall = 2'b10; push_ev(29, 1'b0);
    m_st = 2'b11; m_fc = 1'b0; push_ev(30, 1'b0);
    for (int c = 0; c <= 45; c++) begin
      wait_until(c);
      clear_in();
      if (c >= 7 && c <= 40) commit(0, 32'h1c001000 + 32'(4 * c), 1'b1, 6'h1f);
      if (c >= 7 && c <= 12) commit(1, 32'h1c002000 + 32'(4 * c), 1'b0, 6'h20);
    end

    // Timeout with steady non-success commits.
    rst();
    boot();
    for (int k = 0; k < 6; k++)
      hb_ev(15 + 8 * k, 3'(k % 2), (k % 2 == 1) ? 32'h1c000500 : 32'h1c000400);
    m_st = 2'b11; m_fc = 1'b1; push_ev(58, 1'b0);
    for (int c = 0; c <= 66; c++) begin
      wait_until(c);
      clear_in();
      if (c >= 7) begin
        commit(0, 32'h1c000400, 1'b0, 6'h00);
        commit(1, 32'h1c000500, 1'b1, 6'h1f);
      end
    end

    // Last success lands on the timeout cycle: PASS wins.
    rst();
    boot();
    for (int k = 0; k < 6; k++) begin
      if (k == 2) m_done = 2'b01;
      hb_ev(15 + 8 * k, 3'(k % 2), (k % 2 == 1) ? 32'h1c000500 : 32'h1c000400);
    end
    m_done = 2'b11; push_ev(57, 1'b0);
    m_st = 2'b10;   push_ev(58, 1'b0);
    for (int c = 0; c <= 70; c++) begin
      wait_until(c);
      clear_in();
      if (c >= 7 && c <= 30) commit(0, 32'h1c000400, c == 30, (c == 30) ? 6'h20 : 6'h00);
      if (c >= 7 && c <= 56) commit(1, 32'h1c000500, c == 56, (c == 56) ? 6'h20 : 6'h00);
    end

    // Reset mid-PULSE, then a clean replay with ignored early commits.
    rst();
    m_req = 1; push_ev(4, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      wait_until(c);
      clear_in();
      if (c == 2) commit(0, 32'h1c000600, 1'b1, 6'h20);
      if (c == 5) commit(1, 32'h1c000700, 1'b1, 6'h20);
    end
    rst();
    boot();
    for (int c = 0; c <= 8; c++) begin
      wait_until(c);
      clear_in();
      if (c == 2) begin
        commit(0, 32'h1c000800, 1'b1, 6'h20);
        commit(1, 32'h1c000900, 1'b1, 6'h20);
      end
    end
    probe();
    wait_until(12);
    @(posedge clock);
    #1 finish_req = 1'b1;
  end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
Synthesisable, parametrised successor to the bench-level run monitor, for use in simulation and on the Gowin board. It emulates the power-on reset-button pulse into the SoC and tracks writeback commits from NUM_HARTS cores. It reports PASS when every hart has raised a success exception, and FAIL on a per-hart stall or a global timeout. A round-robin heartbeat exposes each hart's last committed PC and drives the gpio_out LEDs.

Parameters:
NUM_HARTS, 1, number of monitored cores (1..8)
PC_WIDTH, 32, width of each writeback PC
RST_DELAY, 6000, cycles in WAIT before the reset pulse (>=1)
RST_PULSE, 500, cycles core_reset_req is held high (>=1)
HEARTBEAT_CYCLES, 10000, cycles between heartbeat pulses in RUN (>=2)
STALL_CYCLES, 1000000, commit-free cycles on one hart that flag a stall (>=2)
TIMEOUT_CYCLES, 60000000, maximum RUN cycles before timeout (>=2)
CNT_WIDTH, 32, width of all internal counters; must hold the largest cycle parameter

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_valid  in  NUM_HARTS  per-hart writeback commit strobe
wb_pc  in  NUM_HARTS*PC_WIDTH  per-hart writeback PC; hart h occupies bits [h*PC_WIDTH +: PC_WIDTH]
wb_excp  in  NUM_HARTS  per-hart writeback exception flag; qualified by wb_valid
wb_excp_num  in  NUM_HARTS*6  per-hart exception code, 6 bits per hart; bit 5 set means success
core_reset_req  out  1  reset-button emulation into the SoC gpio_in[0]
heartbeat  out  1  one-cycle pulse per heartbeat
heartbeat_hart  out  3  hart index reported by the current heartbeat
heartbeat_pc  out  PC_WIDTH  last committed PC of heartbeat_hart
hart_done  out  NUM_HARTS  sticky per-hart success flags
hart_stall  out  NUM_HARTS  sticky per-hart stall flags
status  out  2  00 = idle/reset, 01 = running, 10 = pass, 11 = fail
fail_cause  out  1  0 = stall, 1 = timeout; valid only when status=11
leds  out  6  board LEDs: {status, fail_cause, heartbeat toggle, |hart_done, |hart_stall}

Behaviour:
- Reset: state=WAIT and all counters cleared. All outputs are 0 on reset: core_reset_req, heartbeat, heartbeat_hart, heartbeat_pc, hart_done, hart_stall, status, fail_cause, leds. Every last-PC register is 0.
- FSM states: WAIT, PULSE, RUN, PASS, FAIL. PASS and FAIL are terminal and are left only by reset.
- WAIT:
  - Counter runs 0..RST_DELAY-1.
  - On the cycle the count equals RST_DELAY-1, the state moves to PULSE.
  - core_reset_req=0; status=00.
- PULSE:
  - core_reset_req=1, registered, for exactly RST_PULSE consecutive cycles; then the state moves to RUN.
  - Commits arriving during WAIT or PULSE are ignored: no last-PC update, no flags.
- RUN:
  - status=01.
  - Global timeout counter increments every cycle.
  - Per-hart idle counters increment every cycle and reset to 0 on that hart's wb_valid.
- Commit on hart h (wb_valid[h]=1 in RUN):
  - lastpc[h] <= wb_pc slice, visible from the next cycle.
  - If wb_excp[h] and wb_excp_num[h][5] are set, hart_done[h] is set on the next cycle and stays set.
- Idle and stall:
  - A done hart's idle counter freezes; a done hart never stalls.
  - When a not-done hart's idle counter reaches STALL_CYCLES-1 without a commit, hart_stall[h] is set.
- Heartbeat:
  - A counter wraps every HEARTBEAT_CYCLES.
  - On wrap, heartbeat pulses for 1 cycle with heartbeat_hart=rr and heartbeat_pc=lastpc[rr] registered together.
  - rr then advances modulo NUM_HARTS.
  - heartbeat_pc holds its value between pulses.
  - An internal toggle flips on each pulse and drives leds[2].
- Terminal decisions, evaluated from the registered flags one cycle after they set:
  - PASS when all hart_done bits are set.
  - Otherwise FAIL with fail_cause=0 if any hart_stall bit is set.
  - Otherwise FAIL with fail_cause=1 when the timeout counter reaches TIMEOUT_CYCLES-1.
  - Priority on the same cycle: PASS > stall > timeout.
- PASS/FAIL: all counters stop, heartbeat is forced to 0, and the flags and status are held.
- Reset at any point, including mid-PULSE, returns to WAIT with core_reset_req=0 on the next cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. RST_DELAY=4, RST_PULSE=3, release reset at cycle 0 -> core_reset_req is 0 for cycles 0-3, 1 for cycles 4-6, 0 from cycle 7; status=01 from cycle 7.
2. NUM_HARTS=2, HEARTBEAT_CYCLES=8; commits hart0 pc=0x1c000100 and hart1 pc=0x1c000200 -> successive heartbeats report (0, 0x1c000100) then (1, 0x1c000200), each exactly 8 cycles apart.
3. NUM_HARTS=2; hart0 commits with excp=1, excp_num=0x20 -> hart_done=01, status stays 01. Later hart1 does the same -> hart_done=11 and status=10 on the following cycle; heartbeat stays 0 afterwards.
4. STALL_CYCLES=16; hart1 stops committing while hart0 keeps committing -> hart_stall=10 after 16 idle cycles, then status=11 and fail_cause=0.
5. TIMEOUT_CYCLES=50 with steady commits and no success -> status=11 and fail_cause=1 after 50 RUN cycles. Repeat with the last success arriving on the timeout cycle -> status=10.
6. Assert reset during PULSE cycle 2 -> core_reset_req=0 next cycle; the full WAIT/PULSE sequence then replays with every flag cleared.
